// File: rtl/oddr_seq_pkg.sv
// Shared types and defaults for the fabric DDR output-lane word sequencer.
package oddr_seq_pkg;

  typedef enum logic {SEQ_TRAIN, SEQ_RUN} seq_state_t;

  localparam logic [19:0] IdleWordDefault  = 20'h0_55AA;
  localparam logic [19:0] TrainWordDefault = 20'hF_C0F0;

  // Width of a counter spanning the dw/2 bit-pair slots of one word.
  function automatic int unsigned phase_width(input int unsigned dw);
    return (dw / 2 > 1) ? $clog2(dw / 2) : 1;
  endfunction

endpackage

// File: rtl/oddr_fabric.sv
// Fabric DDR output stage: registers the rising/falling bit pair, muxes it onto the pin by clock level.
module oddr_fabric #(
  parameter logic DrResetValue_c = 1'b0,
  parameter logic DfResetValue_c = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dr_i,
  input  logic df_i,
  output logic q_o
);

  logic dr_q;
  logic df_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dr_q <= DrResetValue_c;
      df_q <= DfResetValue_c;
    end else begin
      dr_q <= dr_i;
      df_q <= df_i;
    end
  end

  assign q_o = clk_i ? dr_q : df_q;

endmodule

// File: rtl/oddr_tx_sequencer.sv
// Word scheduler for one DDR output lane: hold register, 2-bit/clk shifter, TRAIN/RUN word selection.
module oddr_tx_sequencer
  import oddr_seq_pkg::*;
#(
  parameter int unsigned            DataWidth_c    = 20,
  parameter logic [DataWidth_c-1:0] IdleWord_c     = IdleWordDefault,
  parameter logic [DataWidth_c-1:0] TrainWord_c    = TrainWordDefault,
  parameter int unsigned            TrainRepeat_c  = 16,
  parameter logic                   DrResetValue_c = 1'b0,
  parameter logic                   DfResetValue_c = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DataWidth_c-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   train_req_i,
  output logic                   training_o,
  output logic                   word_start_o,
  output logic                   q_o
);

  localparam int unsigned PhW  = phase_width(DataWidth_c);
  localparam int unsigned CntW = (TrainRepeat_c > 1) ? $clog2(TrainRepeat_c) : 1;
  localparam logic [PhW-1:0]  PhLast  = PhW'(DataWidth_c / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TrainRepeat_c - 1);

  if ((DataWidth_c % 2) != 0 || DataWidth_c < 4) begin : gen_dw_check
    $error("DataWidth_c must be even and >= 4");
  end
  if (TrainRepeat_c < 1) begin : gen_tr_check
    $error("TrainRepeat_c must be >= 1");
  end

  // Async assert, sync release.
  logic [1:0] rst_sync_q;
  logic       srst;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign srst = ~rst_sync_q[1];

  seq_state_t             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PhW-1:0]         phase_q;
  logic [DataWidth_c-1:0] sr_q;
  logic [DataWidth_c-1:0] hold_q;
  logic                   hold_full_q;
  logic                   pend_q;
  logic                   word_start_q;

  logic                   boundary;
  logic                   accept;
  logic                   drain;
  logic [DataWidth_c-1:0] load_word;

  assign ready_o      = ~hold_full_q & ~srst;
  assign training_o   = (state_q == SEQ_TRAIN);
  assign word_start_o = word_start_q;

  // Word choice for the next boundary; cnt_q indexes the train word currently in the shifter.
  always_comb begin
    boundary  = (phase_q == PhLast);
    accept    = valid_i & ready_o;
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain     = 1'b0;
    load_word = IdleWord_c;
    if (pend_q | train_req_i) begin
      state_d   = SEQ_TRAIN;
      cnt_d     = '0;
      load_word = TrainWord_c;
    end else if (state_q == SEQ_TRAIN && cnt_q != CntLast) begin
      cnt_d     = cnt_q + CntW'(1);
      load_word = TrainWord_c;
    end else begin
      state_d   = SEQ_RUN;
      cnt_d     = '0;
      drain     = hold_full_q;
      load_word = hold_full_q ? hold_q : IdleWord_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SEQ_TRAIN;
      cnt_q        <= '0;
      phase_q      <= '0;
      sr_q         <= TrainWord_c;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      pend_q       <= 1'b0;
      word_start_q <= 1'b0;
    end else if (srst) begin
      state_q      <= SEQ_TRAIN;
      cnt_q        <= '0;
      phase_q      <= '0;
      sr_q         <= TrainWord_c;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      pend_q       <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      word_start_q <= boundary;
      if (boundary) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        phase_q <= '0;
        sr_q    <= load_word;
        pend_q  <= 1'b0;
      end else begin
        phase_q <= phase_q + PhW'(1);
        sr_q    <= {2'b00, sr_q[DataWidth_c-1:2]};
        pend_q  <= pend_q | train_req_i;
      end
      if (accept) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end else if (boundary && drain) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  oddr_fabric #(
    .DrResetValue_c (DrResetValue_c),
    .DfResetValue_c (DfResetValue_c)
  ) u_oddr_fabric (
    .clk_i (clk_i),
    .rst_i (srst),
    .dr_i  (sr_q[0]),
    .df_i  (sr_q[1]),
    .q_o   (q_o)
  );

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// Self-checking bench: word-level reference model for q_o plus directed tables and burst sequences.
module tb_oddr_tx_sequencer;

  localparam int unsigned DW    = 20;
  localparam int unsigned TR    = 16;
  localparam logic [19:0] IDLE  = 20'h0_55AA;
  localparam logic [19:0] TRAIN = 20'hF_C0F0;
  localparam logic        DR_RST = 1'b0;
  localparam logic        DF_RST = 1'b0;

  logic        clk;
  logic        rst_n_i;
  logic [19:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        train_req_i;
  logic        training_o;
  logic        word_start_o;
  logic        q_o;

  oddr_tx_sequencer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .train_req_i  (train_req_i),
    .training_o   (training_o),
    .word_start_o (word_start_o),
    .q_o          (q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic obs_ready, obs_training, obs_ws;

  // Reference model: bits still to be sent of the word in the shifter, plus word-level state.
  bit          m_bits[$];
  logic [19:0] m_hold[$];
  bit          m_pend, m_training, m_ws;
  int          m_train_left;
  bit          p_dr, p_df;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic push_word(input logic [19:0] w);
    for (int i = 0; i < DW; i++) m_bits.push_back(w[i]);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_hold.delete();
    push_word(TRAIN);
    m_pend = 0; m_training = 1; m_ws = 0;
    m_train_left = TR - 1;
    p_dr = DR_RST; p_df = DF_RST;
    cyc = 0;
  endtask

  task automatic model_step(input bit v, input logic [19:0] d, input bit req);
    bit acc, bnd;
    acc  = v && (m_hold.size() == 0);
    bnd  = (m_bits.size() == 2);
    p_dr = m_bits.pop_front();
    p_df = m_bits.pop_front();
    m_ws = bnd;
    if (bnd) begin
      if (req || m_pend) begin
        m_training = 1; m_train_left = TR - 1; push_word(TRAIN);
      end else if (m_training && m_train_left > 0) begin
        m_train_left--; push_word(TRAIN);
      end else begin
        m_training = 0;
        if (m_hold.size() != 0) push_word(m_hold.pop_front());
        else                    push_word(IDLE);
      end
      m_pend = 0;
    end else if (req) begin
      m_pend = 1;
    end
    if (acc) m_hold.push_back(d);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step_cycle(input bit v, input logic [19:0] d, input bit req);
    valid_i = v; data_i = d; train_req_i = req;
    #1;
    chk("q_rise", q_o, p_dr);
    chk("ready", ready_o, (m_hold.size() == 0));
    chk("training", training_o, m_training);
    chk("word_start", word_start_o, m_ws);
    obs_ready = ready_o; obs_training = training_o; obs_ws = word_start_o;
    @(negedge clk); #2;
    chk("q_fall", q_o, p_df);
    model_step(v, d, req);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int ncyc, input bit q_from_first);
    rst_n_i = 1'b0; valid_i = 1'b0; data_i = '0; train_req_i = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #2;
      chk("rst_ready", ready_o, 1'b0);
      chk("rst_training", training_o, 1'b1);
      chk("rst_word_start", word_start_o, 1'b0);
      if (q_from_first || i >= 1) chk("rst_q_rise", q_o, DR_RST);
      @(negedge clk); #2;
      if (q_from_first || i >= 1) chk("rst_q_fall", q_o, DF_RST);
    end
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    @(posedge clk); #1;
    chk("sync_release_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic align(input int p);
    for (int i = 0; i < 10 && (cyc % 10) != p; i++) step_cycle(1'b0, '0, 1'b0);
  endtask

  typedef struct {
    bit          v;
    logic [19:0] d;
    int          n;
    bit          exp_ready;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ntr, nws, nrdy, p, lo;
    bit seen, req;

    tbl[0] = '{1'b1, 20'h12345, 1, 1'b1};
    tbl[1] = '{1'b1, 20'hABCDE, 9, 1'b0};
    tbl[2] = '{1'b1, 20'hABCDE, 1, 1'b1};
    tbl[3] = '{1'b1, 20'h00001, 9, 1'b0};
    tbl[4] = '{1'b1, 20'h00001, 1, 1'b1};
    tbl[5] = '{1'b0, 20'h00000, 9, 1'b0};
    tbl[6] = '{1'b0, 20'h00000, 5, 1'b1};

    rst_n_i = 1'b0; valid_i = 1'b0; data_i = '0; train_req_i = 1'b0;

    // 1: power-on training burst then idle.
    do_reset(4, 1'b0);
    ntr = 0; nws = 0;
    for (int i = 0; i < 200; i++) begin
      step_cycle(1'b0, '0, 1'b0);
      if (i == 0) chk("ready_after_release", obs_ready, 1'b1);
      ntr += int'(obs_training);
      nws += int'(obs_ws);
    end
    chk("t1_training_cycles", ntr, 160);
    chk("t1_word_starts", nws, 19);

    // 2: back-to-back words from phase 0 of a RUN word.
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        step_cycle(tbl[k].v, tbl[k].d, 1'b0);
        chk("t2_ready", obs_ready, tbl[k].exp_ready);
        chk("t2_training", obs_training, 1'b0);
      end
    end

    // 3: single word at a chosen phase; hold stays full until the next boundary.
    for (int t = 0; t < 4; t++) begin
      p = (t == 0) ? 0 : (t == 1) ? 9 : int'($urandom_range(0, 9));
      align(p);
      step_cycle(1'b1, 20'($urandom), 1'b0);
      lo = 0;
      for (int i = 0; i < 11; i++) begin
        step_cycle(1'b0, '0, 1'b0);
        lo += int'(!obs_ready);
      end
      chk("t3_hold_cycles", lo, (p == 9) ? 10 : 9 - p);
    end

    // 4a: request mid-word with hold full.
    align(0);
    step_cycle(1'b1, 20'h9_6A5C, 1'b0);
    step_cycle(1'b0, '0, 1'b0);
    step_cycle(1'b0, '0, 1'b0);
    step_cycle(1'b0, '0, 1'b1);
    ntr = 0; nrdy = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      step_cycle(1'b0, '0, 1'b0);
      if (obs_training) begin
        ntr++; seen = 1; nrdy += int'(obs_ready);
      end else if (seen) break;
    end
    chk("t4_burst_cycles", ntr, 160);
    chk("t4_ready_in_train", nrdy, 0);

    // 4b: second request during the 8th train word extends the burst to 24 words.
    align(0);
    step_cycle(1'b0, '0, 1'b1);
    ntr = 0; seen = 0;
    for (int i = 0; i < 500; i++) begin
      req = (ntr == 72);
      step_cycle(1'b0, '0, req);
      if (obs_training) begin
        ntr++; seen = 1;
      end else if (seen) break;
    end
    chk("t4_extended_cycles", ntr, 240);

    // 5: reset mid-word with hold full; held word is discarded.
    align(0);
    step_cycle(1'b1, 20'h3_C3C3, 1'b0);
    step_cycle(1'b0, '0, 1'b0);
    step_cycle(1'b0, '0, 1'b0);
    step_cycle(1'b0, '0, 1'b0);
    do_reset(3, 1'b1);
    ntr = 0;
    for (int i = 0; i < 170; i++) begin
      step_cycle(1'b0, '0, 1'b0);
      ntr += int'(obs_training);
    end
    chk("t5_training_cycles", ntr, 160);

    // 6: random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step_cycle(($urandom % 4) != 0, 20'($urandom), ($urandom % 300) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
